// File: rtl/uart_tx_arb.sv
// Round-robin arbiter that feeds bytes from NREQ requesters to a single UART transmitter core.
// Optional macro UART_TX_ARB_LOCK_EN adds a per-requester lock input that keeps ownership across bytes.
module uart_tx_arb #(
  parameter int NREQ = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_data,
`ifdef UART_TX_ARB_LOCK_EN
  input  logic [NREQ-1:0]   lock,
`endif
  output logic [NREQ-1:0]   ack,
  output logic [NREQ-1:0]   done,
  output logic              busy,
  output logic              tx_start,
  output logic [7:0]        tx_din,
  input  logic              tx_done_tick
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

  state_t            state, state_next;
  logic [IDXW-1:0]   rr_ptr, grant_reg, grant_idx, search_base;
  logic [7:0]        byte_reg;
  logic              grant_valid, grant_fire, finish;

  function automatic logic [IDXW-1:0] wrap_add(input logic [IDXW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return s[IDXW-1:0];
  endfunction

`ifdef UART_TX_ARB_LOCK_EN
  logic owner;
  logic owner_hold;
  assign owner_hold  = owner & lock[grant_reg];
  // Once the owner lets go, the search starts just past it even before rr_ptr catches up.
  assign search_base = owner ? wrap_add(grant_reg, 1) : rr_ptr;
`else
  assign search_base = rr_ptr;
`endif

  // First set request at or after search_base; the lowest offset wins because it is written last.
  always_comb begin
    // NOTE: every variable gets a default before any branch so the block never infers a latch.
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[wrap_add(search_base, k)]) begin
        grant_valid = 1'b1;
        grant_idx   = wrap_add(search_base, k);
      end
    end
`ifdef UART_TX_ARB_LOCK_EN
    if (owner_hold) begin
      grant_valid = req[grant_reg];
      grant_idx   = grant_reg;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    grant_fire = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE:  if (grant_valid) begin
               grant_fire = 1'b1;
               state_next = START;
             end
      START: state_next = WAIT;
      WAIT:  if (tx_done_tick) begin
               finish     = 1'b1;
               state_next = IDLE;
             end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr    <= '0;
      grant_reg <= '0;
      byte_reg  <= '0;
      ack       <= '0;
      done      <= '0;
    end else begin
      ack  <= grant_fire ? (ONE << grant_idx) : '0;
      done <= finish     ? (ONE << grant_reg) : '0;
      if (grant_fire) begin
        grant_reg <= grant_idx;
        byte_reg  <= req_data[{grant_idx, 3'b000} +: 8];
      end
`ifndef UART_TX_ARB_LOCK_EN
      if (finish) rr_ptr <= wrap_add(grant_reg, 1);
`else
      if (finish || (owner && !lock[grant_reg])) begin
        if (!(finish && lock[grant_reg])) rr_ptr <= wrap_add(grant_reg, 1);
      end
`endif
    end
  end

`ifdef UART_TX_ARB_LOCK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                              owner <= 1'b0;
    else if (finish && lock[grant_reg])     owner <= 1'b1;
    else if (finish || !lock[grant_reg])    owner <= 1'b0;
  end
`endif

  assign busy     = (state != IDLE);
  assign tx_start = (state == START);
  assign tx_din   = byte_reg;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed self-checking bench for uart_tx_arb (NREQ=4); the lock scenario runs when UART_TX_ARB_LOCK_EN is defined.
`timescale 1ns/1ps
module tb_uart_tx_arb;

  localparam int NREQ = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] req_data;
`ifdef UART_TX_ARB_LOCK_EN
  logic [NREQ-1:0]   lock;
`endif
  logic [NREQ-1:0]   ack, done;
  logic              busy, tx_start;
  logic [7:0]        tx_din;
  logic              tx_done_tick;

  int vectors     = 0;
  int miscompares = 0;
  int pulse_err   = 0;
  int start_cnt   = 0;
  logic [NREQ-1:0] prev_ack = '0, prev_done = '0;

  uart_tx_arb #(.NREQ(NREQ)) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .req_data     (req_data),
`ifdef UART_TX_ARB_LOCK_EN
    .lock         (lock),
`endif
    .ack          (ack),
    .done         (done),
    .busy         (busy),
    .tx_start     (tx_start),
    .tx_din       (tx_din),
    .tx_done_tick (tx_done_tick)
  );

  always #5 clk = ~clk;

  // Pulses must be one-hot and last exactly one cycle.
  always @(negedge clk) begin
    if ($countones(ack) > 1 || $countones(done) > 1 ||
        (ack & prev_ack) != '0 || (done & prev_done) != '0)
      pulse_err <= pulse_err + 1;
    prev_ack  <= ack;
    prev_done <= done;
    start_cnt <= start_cnt + int'(tx_start);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] onehot(input int idx);
    return 32'd1 << idx;
  endfunction

  // Expects req already presented in IDLE; returns in the cycle where done is visible.
  task automatic serve(input int idx, input logic [7:0] data, input int delay, input bit drop);
    int n;
    n = 0;
    while (tx_start !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check("latency", n, 1);
    check("start", tx_start, 1);
    check("ack", ack, onehot(idx));
    check("tx_din_start", tx_din, data);
    if (drop) req[idx] = 1'b0;
    step();
    check("start_len", tx_start, 0);
    check("ack_len", ack, 0);
    check("busy_wait", busy, 1);
    repeat (delay - 1) step();
    check("done_early", done, 0);
    check("tx_din_wait", tx_din, data);
    tx_done_tick = 1'b1;
    step();
    tx_done_tick = 1'b0;
    check("done", done, onehot(idx));
    check("busy_idle", busy, 0);
  endtask

  initial begin
    int s0;
    reset        = 1'b1;
    req          = '0;
    req_data     = '0;
    tx_done_tick = 1'b0;
`ifdef UART_TX_ARB_LOCK_EN
    lock         = '0;
`endif
    step();
    step();
    check("rst_ack", ack, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_start", tx_start, 0);
    check("rst_din", tx_din, 0);
    reset = 1'b0;
    step();

    // Single request, tick 10 cycles after tx_start
    s0 = start_cnt;
    req_data[7:0] = 8'h55;
    req = 4'b0001;
    serve(0, 8'h55, 10, 1'b1);
    repeat (3) step();
    check("single_busy", busy, 0);
    check("single_starts", start_cnt - s0, 1);

    // All requesters held: strict rotation starting after requester 0
    req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    req = 4'b1111;
    serve(1, 8'hA1, 3, 1'b0);
    serve(2, 8'hA2, 2, 1'b0);
    serve(3, 8'hA3, 4, 1'b0);
    serve(0, 8'hA0, 1, 1'b0);
    serve(1, 8'hA1, 3, 1'b0);
    req = '0;
    step();
    check("rot_idle", busy, 0);

    // Pointer wrap: serve 2 so rr_ptr=3, then 3 before 0
    req_data = {8'hD3, 8'hC2, 8'hB1, 8'hD0};
    req = 4'b0100;
    serve(2, 8'hC2, 2, 1'b1);
    req = 4'b1001;
    serve(3, 8'hD3, 2, 1'b1);
    serve(0, 8'hD0, 2, 1'b1);
    step();

    // Spurious tick in IDLE, early tick in START
    tx_done_tick = 1'b1;
    step();
    tx_done_tick = 1'b0;
    check("spur_idle_done", done, 0);
    check("spur_idle_busy", busy, 0);
    req_data[15:8] = 8'h5A;
    req = 4'b0010;
    step();
    check("early_start", tx_start, 1);
    check("early_din", tx_din, 8'h5A);
    req = '0;
    tx_done_tick = 1'b1;
    step();
    tx_done_tick = 1'b0;
    check("early_done", done, 0);
    check("early_busy", busy, 1);
    repeat (3) step();
    check("early_still_wait", busy, 1);
    check("early_no_done", done, 0);
    tx_done_tick = 1'b1;
    step();
    tx_done_tick = 1'b0;
    check("real_done", done, 4'b0010);
    step();

    // Reset three cycles into the transfer
    req_data[23:16] = 8'h77;
    req = 4'b0100;
    step();
    check("rst_mid_start", tx_start, 1);
    req = '0;
    repeat (3) step();
    check("rst_mid_busy", busy, 1);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_busy0", busy, 0);
    check("rst_mid_din0", tx_din, 0);
    check("rst_mid_start0", tx_start, 0);
    check("rst_mid_ack0", ack, 0);
    check("rst_mid_done0", done, 0);
    step();
    reset = 1'b0;
    // rr_ptr was 2 before reset; a cleared pointer serves 1 before 3
    req_data = {8'h93, 8'h88, 8'h91, 8'h00};
    req = 4'b1010;
    serve(1, 8'h91, 2, 1'b1);
    serve(3, 8'h93, 2, 1'b1);
    step();
    req = 4'b0100;
    serve(2, 8'h88, 5, 1'b1);
    step();

`ifdef UART_TX_ARB_LOCK_EN
    // Requester 0 holds lock for three bytes, then releases
    req_data = {8'h00, 8'h00, 8'hE1, 8'hE0};
    lock = 4'b0001;
    req  = 4'b0011;
    serve(0, 8'hE0, 2, 1'b0);
    serve(0, 8'hE0, 2, 1'b0);
    serve(0, 8'hE0, 2, 1'b0);
    lock = 4'b0000;
    req  = 4'b0010;
    serve(1, 8'hE1, 2, 1'b1);
    step();
`endif

    check("pulse_shape", pulse_err, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
